// File: rtl/instruction_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instruction_mem_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // sll $0,$0,0
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int SHIFT_W        = BYTE_W * (BYTES_PER_WORD - 1);

endpackage

// File: rtl/instr_mem_ram.sv
// Simple dual-port word array: one write port, one registered read port, no reset.
module instr_mem_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_mem_loadable.sv
// Instruction memory loaded big-endian byte by byte while the core is held,
// then serving registered one-cycle fetches with range checking.
//
// state   | meaning
// BOOT    | after reset, no image, core held
// LOAD    | accepting image bytes, core held
// RUN     | image valid, fetches served, core released
module instruction_mem_loadable
    import instruction_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = NOP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_byte_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_byte_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  cpu_hold,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [31:0]           fetch_instr,
    output logic                  fetch_fault
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e              state_q;
    logic [ADDR_WIDTH:0] len_q, word_ptr_q, loaded_cnt_q;
    logic [1:0]          byte_cnt_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic                load_done_q, cpu_hold_q, load_busy_q, fetch_ready_q;
    logic                valid_q, fault_q, use_nop_q;

    logic [ADDR_WIDTH:0] len_clamped;
    logic                byte_acc, word_done, last_word;
    logic                fetch_acc, addr_bad, in_image;
    logic [29:0]         idx;
    logic [31:0]         rd_data;

    assign len_clamped = (load_len > DEPTH) ? DEPTH : load_len;
    assign byte_acc    = (state_q == ST_LOAD) && load_byte_valid;
    assign word_done   = byte_acc && (byte_cnt_q == 2'd3);
    assign last_word   = word_done && (word_ptr_q == len_q - ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            cpu_hold_q    <= 1'b1;
            load_busy_q   <= 1'b0;
            fetch_ready_q <= 1'b0;
            load_done_q   <= 1'b0;
            len_q         <= '0;
            word_ptr_q    <= '0;
            loaded_cnt_q  <= '0;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                ST_BOOT, ST_RUN: begin
                    if (load_start) begin
                        if (len_clamped == '0) begin
                            // Empty image: straight to RUN with nothing reachable
                            state_q       <= ST_RUN;
                            load_done_q   <= 1'b1;
                            loaded_cnt_q  <= '0;
                            cpu_hold_q    <= 1'b0;
                            fetch_ready_q <= 1'b1;
                        end else begin
                            state_q       <= ST_LOAD;
                            len_q         <= len_clamped;
                            word_ptr_q    <= '0;
                            byte_cnt_q    <= '0;
                            cpu_hold_q    <= 1'b1;
                            load_busy_q   <= 1'b1;
                            fetch_ready_q <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (byte_acc) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        shift_q    <= {shift_q[SHIFT_W-BYTE_W-1:0], load_byte};
                        if (word_done) begin
                            word_ptr_q <= word_ptr_q + ONE;
                        end
                        if (last_word) begin
                            state_q       <= ST_RUN;
                            load_done_q   <= 1'b1;
                            loaded_cnt_q  <= len_q;
                            cpu_hold_q    <= 1'b0;
                            load_busy_q   <= 1'b0;
                            fetch_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    // Word index assumes BASE_ADDR is word aligned.
    assign idx       = fetch_addr[31:2] - BASE_ADDR[31:2];
    assign fetch_acc = fetch_req && fetch_ready_q;
    assign addr_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_addr < BASE_ADDR)
                       || (idx[29:ADDR_WIDTH] != '0);
    assign in_image  = ({1'b0, idx[ADDR_WIDTH-1:0]} < loaded_cnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            use_nop_q <= 1'b1;
        end else begin
            valid_q <= fetch_acc;
            if (fetch_acc) begin
                fault_q   <= addr_bad;
                use_nop_q <= addr_bad || !in_image;
            end else begin
                fault_q <= 1'b0;
            end
        end
    end

    instr_mem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (word_done),
        .waddr_i (word_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i ({shift_q, load_byte}),
        .re_i    (fetch_acc),
        .raddr_i (idx[ADDR_WIDTH-1:0]),
        .rdata_o (rd_data)
    );

    assign fetch_instr     = use_nop_q ? NOP_WORD : rd_data;
    assign fetch_valid     = valid_q;
    assign fetch_fault     = fault_q;
    assign fetch_ready     = fetch_ready_q;
    assign cpu_hold        = cpu_hold_q;
    assign load_busy       = load_busy_q;
    assign load_byte_ready = load_busy_q;
    assign load_done       = load_done_q;

endmodule

// File: tb/tb_instruction_mem_loadable.sv
// Self-checking bench: behavioural image model compared every cycle, plus literal spot checks.
module tb_instruction_mem_loadable;

    localparam int          AW    = 8;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          load_byte_valid = 1'b0;
    logic [7:0]    load_byte = '0;
    logic          load_byte_ready, load_busy, load_done, cpu_hold;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_addr = '0;
    logic          fetch_ready, fetch_valid, fetch_fault;
    logic [31:0]   fetch_instr;

    int n_checks = 0;
    int n_err    = 0;

    instruction_mem_loadable #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .NOP_WORD   (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .load_start      (load_start),
        .load_len        (load_len),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_byte_ready (load_byte_ready),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .cpu_hold        (cpu_hold),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: image as an array, bytes gathered in a queue.
    logic [31:0] m_mem [int];
    logic [7:0]  m_bytes [$];
    bit          m_ok = 0, m_run = 0, m_load = 0;
    int          m_loaded = 0, m_len = 0, m_wp = 0;
    logic        e_valid = 0, e_fault = 0, e_done = 0;
    logic [31:0] e_instr = NOP;

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1; m_run = 0; m_load = 0; m_loaded = 0;
            m_bytes.delete();
            e_valid = 0; e_fault = 0; e_done = 0; e_instr = NOP;
        end else begin
            longint unsigned a, b, widx;
            e_done = 0;
            if (fetch_req && m_run) begin
                a = fetch_addr; b = BASE;
                e_valid = 1;
                widx = (a >= b) ? (a - b) / 4 : 0;
                if ((a % 4) != 0 || a < b || widx >= DEPTH) begin
                    e_instr = NOP; e_fault = 1;
                end else if (widx >= m_loaded) begin
                    e_instr = NOP; e_fault = 0;
                end else begin
                    e_instr = m_mem[int'(widx)]; e_fault = 0;
                end
            end else begin
                e_valid = 0; e_fault = 0;
            end
            if (m_load) begin
                if (load_byte_valid) begin
                    m_bytes.push_back(load_byte);
                    if (m_bytes.size() == 4) begin
                        m_mem[m_wp] = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        m_wp++;
                        m_bytes.delete();
                        if (m_wp == m_len) begin
                            m_load = 0; m_run = 1; m_loaded = m_len; e_done = 1;
                        end
                    end
                end
            end else if (load_start) begin
                m_len = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
                if (m_len == 0) begin
                    m_run = 1; m_loaded = 0; e_done = 1;
                end else begin
                    m_load = 1; m_run = 0; m_wp = 0;
                    m_bytes.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cpu_hold", 32'(cpu_hold), 32'(!m_run));
            chk("fetch_ready", 32'(fetch_ready), 32'(m_run));
            chk("load_busy", 32'(load_busy), 32'(m_load));
            chk("load_byte_ready", 32'(load_byte_ready), 32'(m_load));
            chk("load_done", 32'(load_done), 32'(e_done));
            chk("fetch_valid", 32'(fetch_valid), 32'(e_valid));
            chk("fetch_fault", 32'(fetch_fault), 32'(e_fault));
            chk("fetch_instr", fetch_instr, e_instr);
        end
    end

    task automatic start_load(input int n);
        load_start = 1'b1;
        load_len   = (AW+1)'(n);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            load_byte_valid = 1'b1;
            load_byte       = w[31-8*i -: 8];
            @(negedge clk);
        end
        load_byte_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("lit_reset_hold", 32'(cpu_hold), 32'd1);
        chk("lit_reset_ready", 32'(fetch_ready), 32'd0);
        chk("lit_reset_instr", fetch_instr, NOP);
        do_fetch(32'h0);
        chk("lit_boot_fetch_valid", 32'(fetch_valid), 32'd0);

        // Two-word image
        start_load(2);
        send_word(32'h2004_004e);
        send_word(32'h3c10_4000);
        chk("lit_load_done", 32'(load_done), 32'd1);
        chk("lit_hold_with_done", 32'(cpu_hold), 32'd0);
        chk("lit_model_loaded", 32'(m_loaded), 32'd2);

        fetch_req = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        fetch_addr = 32'h4;
        chk("lit_fetch0", fetch_instr, 32'h2004_004e);
        @(negedge clk);
        fetch_req = 1'b0;
        chk("lit_fetch4", fetch_instr, 32'h3c10_4000);
        chk("lit_fetch4_valid", 32'(fetch_valid), 32'd1);

        do_fetch(32'h8);
        chk("lit_fetch8_instr", fetch_instr, NOP);
        chk("lit_fetch8_fault", 32'(fetch_fault), 32'd0);
        do_fetch(32'h2);
        chk("lit_fetch2_fault", 32'(fetch_fault), 32'd1);
        do_fetch(32'h400);
        chk("lit_fetch400_fault", 32'(fetch_fault), 32'd1);
        chk("lit_fetch400_instr", fetch_instr, NOP);
        @(negedge clk);

        // Reset mid-load after three bytes
        start_load(2);
        for (int i = 0; i < 3; i++) begin
            load_byte_valid = 1'b1;
            load_byte       = 8'(8'hA0 + i);
            @(negedge clk);
        end
        load_byte_valid = 1'b0;
        do_reset();
        chk("lit_midload_hold", 32'(cpu_hold), 32'd1);
        chk("lit_midload_busy", 32'(load_busy), 32'd0);
        do_fetch(32'h0);
        chk("lit_midload_fetch_valid", 32'(fetch_valid), 32'd0);

        start_load(1);
        send_word(32'h03e0_0008);
        do_fetch(32'h0);
        chk("lit_reload_fetch0", fetch_instr, 32'h03e0_0008);

        // Reload requested alongside a fetch
        load_start = 1'b1; load_len = (AW+1)'(1);
        fetch_req  = 1'b1; fetch_addr = 32'h4;
        @(negedge clk);
        load_start = 1'b0; fetch_req = 1'b0;
        chk("lit_overlap_valid", 32'(fetch_valid), 32'd1);
        chk("lit_overlap_instr", fetch_instr, NOP);
        chk("lit_overlap_hold", 32'(cpu_hold), 32'd1);
        chk("lit_overlap_ready", 32'(fetch_ready), 32'd0);
        send_word(32'hdead_beef);
        do_fetch(32'h4);
        chk("lit_after_reload_fetch4", fetch_instr, NOP);
        do_fetch(32'h0);
        chk("lit_after_reload_fetch0", fetch_instr, 32'hdead_beef);

        // Oversized length clamps to the full depth
        start_load(300);
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'h1000_0000 + 32'(i));
        end
        chk("lit_clamp_done", 32'(load_done), 32'd1);
        do_fetch(32'h3FC);
        chk("lit_clamp_last", fetch_instr, 32'h1000_00FF);
        do_fetch(32'h0);
        chk("lit_clamp_first", fetch_instr, 32'h1000_0000);
        do_fetch(32'h400);
        chk("lit_clamp_oor_fault", 32'(fetch_fault), 32'd1);

        // Empty image from BOOT
        do_reset();
        start_load(0);
        chk("lit_len0_done", 32'(load_done), 32'd1);
        chk("lit_len0_hold", 32'(cpu_hold), 32'd0);
        do_fetch(32'h0);
        chk("lit_len0_fetch0", fetch_instr, NOP);
        chk("lit_len0_valid", 32'(fetch_valid), 32'd1);
        do_fetch(32'h3FC);
        chk("lit_len0_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_mem_loadable.md
# instruction_mem_loadable

Parametrised, writable instruction memory for the single-cycle/pipelined MIPS core, replacing the fixed hard-coded ROM. A program image is streamed in big-endian byte by byte through a load port while the core is held. Fetches are then served with a registered one-cycle read. Out-of-image fetches return a NOP, and illegal fetches are flagged.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-address width; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- NOP_WORD, 32'h0000_0000: word returned for non-image fetches (sll $0,$0,0).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- load_start  in  1  pulse: begin image load; accepted in BOOT or RUN only.
- load_len  in  ADDR_WIDTH+1  number of words to load; latched with load_start; values above 2^ADDR_WIDTH are clamped.
- load_byte_valid  in  1  byte strobe.
- load_byte  in  8  image byte, most significant byte of each word first.
- load_byte_ready  out  1  high in LOAD.
- load_busy  out  1  high in LOAD.
- load_done  out  1  one-cycle pulse when the image is complete.
- cpu_hold  out  1  high outside RUN; holds the core in reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  byte address (PC).
- fetch_ready  out  1  high in RUN.
- fetch_valid  out  1  response strobe, one cycle after acceptance.
- fetch_instr  out  32  instruction word.
- fetch_fault  out  1  qualifies fetch_valid: misaligned or out-of-range address.

## Operation
- FSM states:
  - BOOT (reset state)
  - LOAD
  - RUN
- Transitions:
  - BOOT→LOAD on load_start with load_len≠0.
  - BOOT→RUN on load_start with load_len=0; load_done pulses.
  - LOAD→RUN after the last byte of word load_len-1 is accepted; load_done pulses in the cycle RUN is entered.
  - RUN→LOAD on load_start with load_len≠0 (reload).
  - load_start while in LOAD is ignored.
- Load datapath:
  - 2-bit byte counter; 3×8-bit shift register.
  - On the 4th accepted byte, write {b0,b1,b2,b3} to mem[word_ptr] and increment word_ptr.
  - word_ptr and byte counter clear on entry to LOAD.
  - loaded_count is set to load_len when load_done pulses.
- Fetch decode (word index idx = (fetch_addr-BASE_ADDR)>>2):
  - fetch_addr[1:0]≠0, fetch_addr<BASE_ADDR, or idx ≥ 2^ADDR_WIDTH → fetch_instr=NOP_WORD, fetch_fault=1.
  - idx ≥ loaded_count → NOP_WORD, fetch_fault=0.
  - Otherwise → mem[idx], fetch_fault=0.
- Fetch requests are accepted only when fetch_ready is high. fetch_req outside RUN is dropped with no response.
- Memory contents are not cleared by reset. loaded_count clears to 0, so all fetches return NOP until a load completes.

## Timing
- Reset values:
  - state=BOOT
  - cpu_hold=1
  - load_byte_ready=0, load_busy=0, load_done=0
  - fetch_ready=0, fetch_valid=0, fetch_fault=0
  - fetch_instr=NOP_WORD
- Fetch latency is exactly 1 cycle, one request per cycle with full throughput. fetch_instr holds its last value while fetch_valid=0.
- A fetch accepted in the same cycle as RUN→LOAD still produces its response in the next cycle.
- Load throughput is 1 byte per cycle, so a load takes 4·load_len cycles plus 1 cycle to enter RUN.
- cpu_hold falls in the same cycle load_done is high.
- Reset mid-load returns to BOOT and discards partial words. Words already written stay in the array but are unreachable (loaded_count=0).
- A memory write and a fetch never coincide, because fetch is only legal in RUN.

## Structure
- Package instruction_mem_pkg:
  - state enum {BOOT, LOAD, RUN}
  - NOP default
  - byte-assembly width constants
- Sub-module instr_mem_ram: 2^ADDR_WIDTH×32 array with one write port and one synchronous read port. It must be inferable as block RAM.
- The top level contains the FSM, the byte assembler, and the fetch range check. The range-check result is registered alongside the read data.

## Test plan
- Reset, then fetch 0x0 → no response; cpu_hold=1, fetch_ready=0.
- load_len=2, stream bytes 20 04 00 4e 3c 10 40 00 → load_done after the 8th byte; then fetch 0x0 and 0x4 back-to-back → 0x2004004e, 0x3c104000 on consecutive cycles, fault=0.
- After that load, fetch 0x8 → NOP_WORD, fault=0. Fetch 0x2 → NOP_WORD, fault=1. Fetch 0x400 with ADDR_WIDTH=8 → NOP_WORD, fault=1.
- Assert reset after 3 bytes of a load → state=BOOT, fetches return no data. Reload 1 word 0x03e00008 → fetch 0x0 returns 0x03e00008.
- In RUN, pulse load_start (load_len=1) in the same cycle as a fetch of 0x4 → the fetch response arrives next cycle, cpu_hold=1, fetch_ready=0. After 4 bytes, RUN is re-entered and 0x4 returns NOP_WORD.
- load_len=0 → load_done next cycle, RUN entered, every fetch returns NOP_WORD.
